seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width; legal range 4..32.
REQ-002 Parameter DIV_RADIX_BITS, default 1: quotient bits produced per divide cycle; legal values 1 and 2; WIDTH SHALL be divisible by it.
REQ-003 clk  input  1  Single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  Operation request valid.
REQ-006 in_ready  output  1  Block can accept a request this cycle.
REQ-007 a, b  input  WIDTH each  Operands, unsigned unless the opcode says otherwise.
REQ-008 alu_sel  input  4  Opcode, sampled only on accept.
REQ-009 out_valid  output  1  Result and flags valid.
REQ-010 out_ready  input  1  Consumer accepts the result.
REQ-011 result  output  WIDTH  Primary result; quotient for divide.
REQ-012 result_hi  output  WIDTH  Multiply upper half or divide remainder; 0 for all other opcodes.
REQ-013 carry, overflow, zero, div_by_zero  output  1 each  Status flags.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; a, b and alu_sel SHALL be captured at that edge.
REQ-015 FSM states: IDLE, DIV, DONE; IDLE --accept non-divide--> DONE; IDLE --accept divide with b!=0--> DIV; DIV --last iteration--> DONE; DONE --out_ready && !accept--> IDLE; DONE --out_ready && accept--> DONE or DIV, per the new opcode.
REQ-016 in_ready = (state==IDLE) || (state==DONE && out_ready); it SHALL be low in DIV.
REQ-017 out_valid = (state==DONE); result and flags SHALL hold stable while out_valid && !out_ready.
REQ-018 Non-divide latency: out_valid rises on the edge after accept, so back-to-back throughput is one operation per cycle.
REQ-019 Divide latency with b!=0: out_valid rises WIDTH/DIV_RADIX_BITS + 1 edges after accept.
REQ-020 Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 SHL a by 1, 9 SHR a by 1 (logical), A ASR a by 1, B ROL a by b[log2 WIDTH-1:0], C SLT signed (result = 1 or 0); D-F yield result=0 with all flags 0 except zero=1.
REQ-021 ADD: carry = bit WIDTH of the unsigned sum; overflow = two's-complement signed overflow.
REQ-022 SUB: carry = borrow (a<b unsigned); overflow = signed overflow of a-b.
REQ-023 MUL: unsigned full product {result_hi,result}; overflow = |result_hi; carry=0.
REQ-024 DIV with b!=0: restoring unsigned division; result = a/b, result_hi = a%b.
REQ-025 DIV with b==0: single-cycle path as in REQ-018; div_by_zero=1, result = all ones, result_hi = a.
REQ-026 For shifts, SHL carry = a[WIDTH-1] and SHR/ASR carry = a[0]; for logic ops, NOT, ROL and SLT, carry = overflow = 0.
REQ-027 zero = (result==0), registered with the result; result_hi does not affect it.
REQ-028 Inputs SHALL be ignored while in_ready=0 and SHALL NOT disturb a divide in progress.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, out_valid=0, result=0, result_hi=0, all flags 0, divider registers 0.
REQ-030 Reset mid-divide SHALL abort the operation with no result produced; in_ready=1 on the first edge after rst_n deasserts.

Structure
REQ-031 Package seq_alu_pkg SHALL hold the opcode constants and the FSM state encoding.
REQ-032 Sub-module seq_alu_div SHALL implement the iterative divider (start, busy/done, quotient, remainder), parametrised by WIDTH and DIV_RADIX_BITS.

Verification
REQ-033 WIDTH=8, ADD a=8'hFF, b=8'h01 -> next cycle result=8'h00, carry=1, zero=1, overflow=0.
REQ-034 ADD a=8'h7F, b=8'h01 -> result=8'h80, overflow=1, carry=0; SUB a=8'h03, b=8'h05 -> result=8'hFE, carry=1.
REQ-035 MUL a=8'h10, b=8'h20 -> result=8'h00, result_hi=8'h02, overflow=1, zero=1.
REQ-036 DIV a=200, b=7, DIV_RADIX_BITS=1 -> out_valid 9 edges after accept, result=28, result_hi=4; b=0 -> next cycle div_by_zero=1, result=8'hFF, result_hi=200.
REQ-037 Back-to-back: 4 ADDs with in_valid held high and out_ready=1 -> 4 results on consecutive cycles; out_ready=0 for 3 cycles -> result held and in_ready=0.
REQ-038 Assert rst_n=0 during DIV cycle 4 -> out_valid=0 immediately; after release, a new SUB completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode constants and FSM state encoding for seq_alu.
//   OP_*    : 4-bit alu_sel opcodes (0xD..0xF are reserved and yield zero)
//   state_e : control FSM states (IDLE, DIV, DONE)
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ASR = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_SLT = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Divides with a zero divisor bypass the iterative divider.
  function automatic logic needs_divider(input logic [3:0] op, input logic b_is_zero);
    return (op == OP_DIV) && !b_is_zero;
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// seq_alu_div: iterative restoring unsigned divider, DIV_RADIX_BITS quotient
// bits per clock, WIDTH/DIV_RADIX_BITS iterations per divide.
//   clk, rst_n              : clock, async active-low reset
//   i_start                 : load operands and begin (divisor must be non-zero)
//   i_dividend, i_divisor   : operands, sampled when i_start is high
//   o_busy                  : iterations remaining
//   o_done                  : the iteration executing this cycle is the last one
//   o_quotient, o_remainder : result of the iteration executing this cycle;
//                             final values while o_done is high
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIV_RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned ITERS = WIDTH / DIV_RADIX_BITS;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH:0]   w_trial;

  // One clock's worth of restoring steps. The partial remainder stays below
  // the divisor, so the trial value needs only one extra bit.
  always_comb begin
    w_rem   = r_rem;
    w_quo   = r_quo;
    w_trial = '0;
    for (int unsigned k = 0; k < DIV_RADIX_BITS; k++) begin
      w_trial = {w_rem, w_quo[WIDTH-1]};
      w_quo   = {w_quo[WIDTH-2:0], 1'b0};
      if (w_trial >= {1'b0, r_dvs}) begin
        w_trial  = w_trial - {1'b0, r_dvs};
        w_quo[0] = 1'b1;
      end
      w_rem = w_trial[WIDTH-1:0];
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_cnt == CNT_W'(1));
  assign o_quotient  = w_quo;
  assign o_remainder = w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= CNT_W'(ITERS);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem;
      r_quo <= w_quo;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accept edge; non-zero divides run through
// seq_alu_div and complete WIDTH/DIV_RADIX_BITS edges later.
//   clk, rst_n                  : clock, async active-low reset
//   in_valid, in_ready          : request handshake
//   a, b, alu_sel               : operands and opcode, captured on accept
//   out_valid, out_ready        : result handshake
//   result, result_hi           : result (quotient) and upper product / remainder
//   carry, overflow, zero,
//   div_by_zero                 : status flags, registered with the result
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIV_RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_dbz;

  logic               w_accept;
  logic               w_div_start;
  logic               w_div_busy;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_q;
  logic [WIDTH-1:0]   w_div_r;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  int unsigned        w_rot;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_hi;
  logic               w_c;
  logic               w_v;
  logic               w_dbz;

  assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid   = (r_state == ST_DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_div_start = w_accept && needs_divider(alu_sel, (b == '0));

  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign carry       = r_carry;
  assign overflow    = r_overflow;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;

  seq_alu_div #(
    .WIDTH          (WIDTH),
    .DIV_RADIX_BITS (DIV_RADIX_BITS)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_dividend  (a),
    .i_divisor   (b),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_q),
    .o_remainder (w_div_r)
  );

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = a - b;
  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  // Rotate amount reduced modulo WIDTH so non-power-of-two widths still rotate.
  assign w_rot  = 32'(b[SHW-1:0]) % WIDTH;

  // Single-cycle datapath; also covers divide-by-zero.
  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_dbz = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (a < b);
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        w_hi  = w_prod[2*WIDTH-1:WIDTH];
        w_v   = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_res = '1;
        w_hi  = a;
        w_dbz = 1'b1;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: begin
        w_res = {a[WIDTH-2:0], 1'b0};
        w_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, a[WIDTH-1:1]};
        w_c   = a[0];
      end
      OP_ASR: begin
        w_res = {a[WIDTH-1], a[WIDTH-1:1]};
        w_c   = a[0];
      end
      OP_ROL: w_res = (a << w_rot) | (a >> (WIDTH - w_rot));
      OP_SLT: w_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_div_start) begin
              r_state <= ST_DIV;
            end else begin
              r_state     <= ST_DONE;
              r_result    <= w_res;
              r_result_hi <= w_hi;
              r_carry     <= w_c;
              r_overflow  <= w_v;
              r_zero      <= (w_res == '0);
              r_dbz       <= w_dbz;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_state     <= ST_DONE;
            r_result    <= w_div_q;
            r_result_hi <= w_div_r;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= (w_div_q == '0);
            r_dbz       <= 1'b0;
          end else if (!w_div_busy) begin
            // Divider idle without having finished: drop back rather than hang.
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
